// File: rtl/deaccumulator_if.sv
// Job/result bundle for the deaccumulator: job request (valid/ready), drain controls,
// and result (valid/ready) with status.
interface deaccumulator_if #(
  parameter int unsigned BITWIDTH = 32
);
  logic                  en;
  logic                  clr;
  logic                  in_valid;
  logic                  in_ready;
  logic [BITWIDTH:0]     total;
  logic [BITWIDTH-1:0]   step;
  logic                  out_valid;
  logic                  out_ready;
  logic [BITWIDTH:0]     count;
  logic [BITWIDTH-1:0]   rem;
  logic                  err;
  logic                  busy;

  // Upstream/downstream environment side
  modport master (
    output en, clr, in_valid, total, step, out_ready,
    input  in_ready, out_valid, count, rem, err, busy
  );

  // Deaccumulator side
  modport slave (
    input  en, clr, in_valid, total, step, out_ready,
    output in_ready, out_valid, count, rem, err, busy
  );
endinterface

// File: rtl/deaccumulator.sv
// Drains an accumulated total by a fixed step, one subtraction per enabled cycle,
// and reports the number of whole steps removed plus the leftover residue.
module deaccumulator #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  deaccumulator_if.slave  bus
);

  localparam int unsigned TW = BITWIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         residue_q, residue_d;
  logic [BITWIDTH-1:0]   step_q, step_d;
  logic [TW-1:0]         tally_q, tally_d;
  logic [TW-1:0]         count_q, count_d;
  logic [BITWIDTH-1:0]   rem_q, rem_d;
  logic                  err_q, err_d;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic [TW-1:0]         step_ext_c;

  // Step is zero-extended so compare/subtract live in the total's width and never wrap
  assign step_ext_c = TW'(step_q);

  // Next-state and result logic; clear overrides everything except reset
  always_comb begin
    state_d   = state_q;
    residue_d = residue_q;
    step_d    = step_q;
    tally_d   = tally_q;
    count_d   = count_q;
    rem_d     = rem_q;
    err_d     = err_q;

    if (bus.clr) begin
      state_d = S_IDLE;
      tally_d = '0;
      count_d = '0;
      rem_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            residue_d = bus.total;
            step_d    = bus.step;
            tally_d   = '0;
            if (bus.step == '0) begin
              state_d = S_DONE;
              err_d   = 1'b1;
              count_d = '0;
              rem_d   = bus.total[BITWIDTH-1:0];
            end else begin
              state_d = S_RUN;
            end
          end
        end

        S_RUN: begin
          if (bus.en) begin
            if (residue_q >= step_ext_c) begin
              residue_d = residue_q - step_ext_c;
              tally_d   = tally_q + TW'(1);
            end else begin
              state_d = S_DONE;
              count_d = tally_q;
              rem_d   = residue_q[BITWIDTH-1:0];
              err_d   = 1'b0;
            end
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; handshake flags are decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      residue_q   <= '0;
      step_q      <= '0;
      tally_q     <= '0;
      count_q     <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      residue_q   <= residue_d;
      step_q      <= step_d;
      tally_q     <= tally_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d == S_RUN);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.count     = count_q;
  assign bus.rem       = rem_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_deaccumulator.sv
// Self-checking bench for deaccumulator: job-level arithmetic model checked every cycle,
// plus directed jobs with hand-computed counts, remainders and latencies.
module tb_deaccumulator;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = W + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  deaccumulator_if #(.BITWIDTH(W)) bus ();

  deaccumulator #(.BITWIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: a job yields T/S and T%S after T/S+1 enabled drain cycles
  logic          m_ready, m_valid, m_busy, m_err;
  logic [TW-1:0] m_count, p_count;
  logic [W-1:0]  m_rem, p_rem;
  longint        m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_busy <= 1'b0; m_err <= 1'b0;
      m_count <= '0;   m_rem   <= '0;   p_count <= '0;  p_rem <= '0;
      m_left  <= 0;
    end else if (bus.clr) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_busy <= 1'b0; m_err <= 1'b0;
      m_count <= '0;   m_rem   <= '0;
    end else if (m_ready && bus.in_valid) begin
      m_ready <= 1'b0;
      if (bus.step == '0) begin
        m_valid <= 1'b1;
        m_err   <= 1'b1;
        m_count <= '0;
        m_rem   <= bus.total[W-1:0];
      end else begin
        m_busy  <= 1'b1;
        m_left  <= longint'(bus.total / TW'(bus.step)) + 1;
        p_count <= bus.total / TW'(bus.step);
        p_rem   <= W'(bus.total % TW'(bus.step));
      end
    end else if (m_busy && bus.en) begin
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_count <= p_count;
        m_rem   <= p_rem;
        m_err   <= 1'b0;
      end
      m_left <= m_left - 1;
    end else if (m_valid && bus.out_ready) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      chk("cyc in_ready",  bus.in_ready,  m_ready);
      chk("cyc out_valid", bus.out_valid, m_valid);
      chk("cyc busy",      bus.busy,      m_busy);
      chk("cyc count",     bus.count,     m_count);
      chk("cyc rem",       bus.rem,       m_rem);
      chk("cyc err",       bus.err,       m_err);
    end
  end

  task automatic submit(input logic [TW-1:0] t, input logic [W-1:0] s);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.total    = t;
    bus.step     = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [TW-1:0] ec, input logic [W-1:0] er,
                           input logic ee, input int ecyc, input bit toggle);
    int cyc   = 0;
    int guard = 0;
    while (!bus.out_valid && guard < 5000) begin
      if (bus.busy) cyc++;
      if (toggle) bus.en = ~bus.en;
      @(negedge clk);
      guard++;
    end
    bus.en = 1'b1;
    chk({name, " valid"},  bus.out_valid, 1);
    chk({name, " count"},  bus.count, ec);
    chk({name, " rem"},    bus.rem, er);
    chk({name, " err"},    bus.err, ee);
    chk({name, " cycles"}, cyc, ecyc);
  endtask

  task automatic release_result(input string name, input int hold);
    repeat (hold) @(negedge clk);
    chk({name, " held valid"}, bus.out_valid, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, " back ready"}, bus.in_ready, 1);
    chk({name, " back valid"}, bus.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b1; bus.clr = 1'b0; bus.in_valid = 1'b0;
    bus.total = '0; bus.step = '0; bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst in_ready",  bus.in_ready,  1);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst busy",      bus.busy,      0);
    chk("rst count",     bus.count,     0);
    chk("rst rem",       bus.rem,       0);
    chk("rst err",       bus.err,       0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    submit(33'd400, 32'd10);
    wait_done("t400s10", 33'd40, 32'd0, 1'b0, 41, 1'b0);
    release_result("t400s10", 0);

    submit(33'd405, 32'd10);
    wait_done("t405s10", 33'd40, 32'd5, 1'b0, 41, 1'b0);
    release_result("backpressure", 20);

    submit(33'd5, 32'd10);
    wait_done("t5s10", 33'd0, 32'd5, 1'b0, 1, 1'b0);
    release_result("t5s10", 0);

    submit(33'd77, 32'd0);
    wait_done("zero step", 33'd0, 32'd77, 1'b1, 0, 1'b0);
    release_result("zero step", 0);

    submit(33'd100, 32'd10);
    wait_done("en toggle", 33'd10, 32'd0, 1'b0, 22, 1'b1);
    release_result("en toggle", 0);

    submit(33'd10, 32'd10);
    wait_done("exact", 33'd1, 32'd0, 1'b0, 2, 1'b0);
    release_result("exact", 0);

    submit(33'h1_FFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("wide", 33'd2, 32'd1, 1'b0, 3, 1'b0);
    release_result("wide", 0);

    // Abort mid-drain with a job offered in the same cycle; it must wait for the next cycle
    submit(33'd400, 32'd10);
    repeat (4) @(negedge clk);
    bus.clr = 1'b1; bus.in_valid = 1'b1; bus.total = 33'd30; bus.step = 32'd10;
    @(negedge clk);
    chk("clr in_ready",  bus.in_ready,  1);
    chk("clr out_valid", bus.out_valid, 0);
    chk("clr busy",      bus.busy,      0);
    chk("clr count",     bus.count,     0);
    bus.clr = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done("after clr", 33'd3, 32'd0, 1'b0, 4, 1'b0);
    release_result("after clr", 0);

    // Async reset mid-drain
    submit(33'd400, 32'd10);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst in_ready",  bus.in_ready,  1);
    chk("arst out_valid", bus.out_valid, 0);
    chk("arst busy",      bus.busy,      0);
    chk("arst count",     bus.count,     0);
    chk("arst rem",       bus.rem,       0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst release ready", bus.in_ready, 1);

    submit(33'd5, 32'd10);
    wait_done("post reset", 33'd0, 32'd5, 1'b0, 1, 1'b0);
    release_result("post reset", 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
